// File: rtl/sm_accumulator.sv
// Sign-magnitude integrate-and-dump accumulator: convert, count at the input,
// saturating accumulate in stage 2, and dump with a one-cycle strobe.
module sm_accumulator #(
    parameter int IN_WIDTH    = 3,
    parameter int ACC_WIDTH   = 16,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_dump_length,
    input  logic                   i_sample_valid,
    input  logic [IN_WIDTH-1:0]    i_sample,
    output logic [ACC_WIDTH-1:0]   o_accumulator,
    output logic                   o_dump_valid,
    output logic                   o_overflow,
    output logic                   o_busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_len, r_count;
    logic                   r_s1_vld, r_s1_last;
    logic [ACC_WIDTH-1:0]   r_s1_x, r_sum;
    logic                   r_flag;

    logic                   w_start_go, w_accept, w_last;
    logic [COUNT_WIDTH-1:0] w_len_eff, w_cnt_base, w_cnt_inc;
    logic [ACC_WIDTH-1:0]   w_mag, w_x, w_sat;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_pos_clamp, w_neg_clamp, w_clamp;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_start)
            w_state_nxt = (i_dump_length != '0) ? S_RUN : S_IDLE;
    end

    assign o_busy = (r_state == S_RUN);

    // A start cycle opens the new period, so its sample counts against the new length.
    assign w_start_go = i_start && (i_dump_length != '0);
    assign w_accept   = i_sample_valid && (w_start_go || (r_state == S_RUN && !i_start));
    assign w_len_eff  = w_start_go ? i_dump_length : r_len;
    assign w_cnt_base = i_start ? '0 : r_count;
    assign w_cnt_inc  = w_cnt_base + 1'b1;
    assign w_last     = w_accept && (w_cnt_inc == w_len_eff);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len   <= '0;
            r_count <= '0;
        end else begin
            if (w_start_go) r_len <= i_dump_length;
            r_count <= w_accept ? (w_last ? '0 : w_cnt_inc) : w_cnt_base;
        end
    end

    // Negative zero falls out naturally: -0 == 0.
    assign w_mag = {{(ACC_WIDTH-IN_WIDTH+1){1'b0}}, i_sample[IN_WIDTH-2:0]};
    assign w_x   = i_sample[IN_WIDTH-1] ? (~w_mag + 1'b1) : w_mag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_x    <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_last <= w_last;
            r_s1_x    <= w_x;
        end
    end

    // One guard bit: the top two sum bits disagree exactly when the result leaves range.
    assign w_sum       = {r_sum[ACC_WIDTH-1], r_sum} + {r_s1_x[ACC_WIDTH-1], r_s1_x};
    assign w_pos_clamp = !w_sum[ACC_WIDTH] &&  w_sum[ACC_WIDTH-1];
    assign w_neg_clamp =  w_sum[ACC_WIDTH] && !w_sum[ACC_WIDTH-1];
    assign w_clamp     = w_pos_clamp || w_neg_clamp;
    assign w_sat       = w_pos_clamp ? {1'b0, {(ACC_WIDTH-1){1'b1}}} :
                         w_neg_clamp ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                       w_sum[ACC_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum         <= '0;
            r_flag        <= 1'b0;
            o_accumulator <= '0;
            o_overflow    <= 1'b0;
            o_dump_valid  <= 1'b0;
        end else begin
            o_dump_valid <= 1'b0;
            if (i_start) begin
                // Squash the stage-1 entry: the old period never dumps.
                r_sum  <= '0;
                r_flag <= 1'b0;
            end else if (r_s1_vld) begin
                if (r_s1_last) begin
                    o_accumulator <= w_sat;
                    o_overflow    <= r_flag || w_clamp;
                    o_dump_valid  <= 1'b1;
                    r_sum         <= '0;
                    r_flag        <= 1'b0;
                end else begin
                    r_sum  <= w_sat;
                    r_flag <= r_flag || w_clamp;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Drives a 16-bit and a 4-bit accumulator with shared stimulus and checks both
// against a period-level saturating-sum model every cycle.
module tb_sm_accumulator;

    logic       clk = 1'b0;
    logic       rst, st, sv;
    logic [9:0] dl;
    logic [2:0] smp;

    logic [15:0] acc16;
    logic [3:0]  acc4;
    logic        dv16, ovf16, busy16, dv4, ovf4, busy4;

    sm_accumulator #(.IN_WIDTH(3), .ACC_WIDTH(16), .COUNT_WIDTH(10)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_start(st), .i_dump_length(dl),
        .i_sample_valid(sv), .i_sample(smp),
        .o_accumulator(acc16), .o_dump_valid(dv16), .o_overflow(ovf16), .o_busy(busy16));

    sm_accumulator #(.IN_WIDTH(3), .ACC_WIDTH(4), .COUNT_WIDTH(10)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_start(st), .i_dump_length(dl),
        .i_sample_valid(sv), .i_sample(smp),
        .o_accumulator(acc4), .o_dump_valid(dv4), .o_overflow(ovf4), .o_busy(busy4));

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int a16;
        bit o16;
        int a4;
        bit o4;
    } dump_t;

    dump_t pq[$];
    int    smp_q[$];
    int    n_chk = 0, n_err = 0, cyc = 0;
    int    len_m = 0, e16 = 0, e4 = 0;
    bit    busy_m = 0, eo16 = 0, eo4 = 0, armed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void runsum(input int w, output int s, output bit f);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        s = 0;
        f = 0;
        foreach (smp_q[i]) begin
            s += smp_q[i];
            if (s > mx) begin s = mx; f = 1; end
            else if (s < mn) begin s = mn; f = 1; end
        end
    endfunction

    task automatic step(input bit r, input bit s, input int len, input bit v, input int code);
        bit    edv;
        bit [2:0] c3;
        int    val;
        dump_t d;
        @(negedge clk);
        edv = 0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            d = pq.pop_front();
            edv = 1; e16 = d.a16; eo16 = d.o16; e4 = d.a4; eo4 = d.o4;
        end
        if (armed) begin
            chk("dv16",   {31'b0, dv16},   {31'b0, edv});
            chk("acc16",  {16'b0, acc16},  e16 & 32'hFFFF);
            chk("ovf16",  {31'b0, ovf16},  {31'b0, eo16});
            chk("busy16", {31'b0, busy16}, {31'b0, busy_m});
            chk("dv4",    {31'b0, dv4},    {31'b0, edv});
            chk("acc4",   {28'b0, acc4},   e4 & 32'hF);
            chk("ovf4",   {31'b0, ovf4},   {31'b0, eo4});
            chk("busy4",  {31'b0, busy4},  {31'b0, busy_m});
        end
        rst = r; st = s; dl = 10'(len); sv = v; smp = 3'(code);
        if (r) begin
            pq.delete(); smp_q.delete();
            busy_m = 0; e16 = 0; e4 = 0; eo16 = 0; eo4 = 0; armed = 1;
        end else begin
            if (s) begin
                // The sample whose last tag sits in stage 1 now would dump next cycle.
                if (pq.size() > 0 && pq[pq.size()-1].due == cyc + 1) void'(pq.pop_back());
                smp_q.delete();
                busy_m = (len != 0);
                if (len != 0) len_m = len;
            end
            if (v && busy_m) begin
                c3 = 3'(code);
                val = c3[2] ? -int'(c3[1:0]) : int'(c3[1:0]);
                smp_q.push_back(val);
                if (smp_q.size() == len_m) begin
                    d.due = cyc + 2;
                    runsum(16, d.a16, d.o16);
                    runsum(4, d.a4, d.o4);
                    pq.push_back(d);
                    smp_q.delete();
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; st = 0; dl = '0; sv = 0; smp = '0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);
        // basic length-4 stream, then repeated periods
        step(0, 1, 4, 0, 0);
        for (int p = 0; p < 3; p++) begin
            step(0, 0, 0, 1, 3'b011); step(0, 0, 0, 1, 3'b101);
            step(0, 0, 0, 1, 3'b011); step(0, 0, 0, 1, 3'b100);
        end
        idle(4);
        // reset mid-run with samples still arriving
        step(0, 1, 3, 1, 3'b011);
        step(0, 0, 0, 1, 3'b010);
        step(0, 0, 0, 1, 3'b001);
        step(1, 0, 0, 1, 3'b011);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 3'b011);
        idle(3);
        // sparse valid
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 3'b111);
        idle(5);
        step(0, 0, 0, 1, 3'b111);
        idle(4);
        // saturation periods
        step(0, 1, 4, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'b011);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'b001);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'b111);
        idle(4);
        // restart mid-period with a sample in the start cycle
        step(0, 1, 4, 0, 0);
        step(0, 0, 0, 1, 3'b011); step(0, 0, 0, 1, 3'b011);
        step(0, 1, 2, 1, 3'b001); step(0, 0, 0, 1, 3'b001);
        idle(4);
        // start colliding with the old last in stage 1
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 3'b011); step(0, 0, 0, 1, 3'b011); step(0, 0, 0, 1, 3'b011);
        step(0, 1, 5, 0, 0);
        idle(4);
        // zero-length start
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 3'b011);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, v;
            int len;
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 24) == 0);
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
            v   = ($urandom_range(0, 9) < 7);
            step(r, s, len, v, $urandom_range(0, 7));
        end
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
